// File: rtl/cpu_bus1_arbiter.sv
// cpu_bus1_arbiter
// Round-robin arbiter that shares the CPU-side cache bus (A1/D1/C1) between
// two requester ports. One transaction is outstanding at a time. Each one is
// sent as a two-cycle command/address burst. The arbiter then waits for
// C1_RESPONSE, collects any read data and reports completion to the winning port.
module cpu_bus1_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int OFFSET_W     = 4,
    parameter int ADDR1_W      = 15,
    parameter int DATA_W       = 16,
    parameter int CTR1_W       = 3,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          req_valid,
    input  logic [CTR1_W-1:0]   req_cmd0,
    input  logic [CTR1_W-1:0]   req_cmd1,
    input  logic [ADDR_W-1:0]   req_addr0,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [31:0]         req_wdata0,
    input  logic [31:0]         req_wdata1,
    output logic [1:0]          req_ready,
    output logic [1:0]          resp_valid,
    output logic                resp_err,
    output logic [31:0]         resp_rdata,
    inout  wire  [ADDR1_W-1:0]  A1,
    inout  wire  [DATA_W-1:0]   D1,
    inout  wire  [CTR1_W-1:0]   C1
);

    localparam logic [CTR1_W-1:0] CMD_NOP     = CTR1_W'(0);
    localparam logic [CTR1_W-1:0] CMD_READ8   = CTR1_W'(1);
    localparam logic [CTR1_W-1:0] CMD_READ16  = CTR1_W'(2);
    localparam logic [CTR1_W-1:0] CMD_READ32  = CTR1_W'(3);
    localparam logic [CTR1_W-1:0] CMD_WRITE8  = CTR1_W'(5);
    localparam logic [CTR1_W-1:0] CMD_WRITE16 = CTR1_W'(6);
    localparam logic [CTR1_W-1:0] CMD_WRITE32 = CTR1_W'(7);
    localparam logic [CTR1_W-1:0] C1_RESPONSE = CTR1_W'(7);

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND1,
        S_SEND2,
        S_WAIT_RESP,
        S_RECV,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                port_q, port_d;
    logic [CTR1_W-1:0]   cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          req_ready_q, req_ready_d;
    logic [1:0]          resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;

    // Arbitration and per-port decode helpers
    logic                winner;
    logic [1:0]          win_onehot;
    logic [1:0]          port_onehot;

    // Rotating priority only matters when both ports ask at once
    assign winner = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign win_onehot[gi]  = (winner == 1'(gi));
            assign port_onehot[gi] = (port_q == 1'(gi));
        end
    endgenerate

    // Bus drive: only during the two send cycles, D1 only for writes
    logic                bus_drive;
    logic                is_write;
    logic [ADDR1_W-1:0]  a1_val;
    logic [DATA_W-1:0]   d1_val;

    assign bus_drive = (state_q == S_SEND1) || (state_q == S_SEND2);
    assign is_write  = (cmd_q == CMD_WRITE8) || (cmd_q == CMD_WRITE16) ||
                       (cmd_q == CMD_WRITE32);
    assign a1_val    = (state_q == S_SEND1) ? addr_q[ADDR_W-1:OFFSET_W]
                     : {{(ADDR1_W-OFFSET_W){1'b0}}, addr_q[OFFSET_W-1:0]};
    assign d1_val    = (state_q == S_SEND1) ? wdata_q[DATA_W-1:0]
                                            : wdata_q[2*DATA_W-1:DATA_W];

    assign A1 = bus_drive              ? a1_val : 'z;
    assign D1 = (bus_drive && is_write) ? d1_val : 'z;
    assign C1 = bus_drive              ? cmd_q  : 'z;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // State register and transaction latches; reset also releases the bus at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            port_q       <= 1'b0;
            cmd_q        <= CMD_NOP;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            req_ready_q  <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            port_q       <= port_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state logic: grant, send, wait for response/timeout, collect, report
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        port_d       = port_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        req_ready_d  = 2'b00;
        resp_valid_d = 2'b00;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    port_d      = winner;
                    cmd_d       = winner ? req_cmd1   : req_cmd0;
                    addr_d      = winner ? req_addr1  : req_addr0;
                    wdata_d     = winner ? req_wdata1 : req_wdata0;
                    rr_ptr_d    = ~winner;
                    req_ready_d = win_onehot;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    // A NOP never touches the bus and completes immediately
                    state_d     = (cmd_d == CMD_NOP) ? S_DONE : S_SEND1;
                end
            end
            S_SEND1: begin
                state_d = S_SEND2;
            end
            S_SEND2: begin
                cnt_d   = '0;
                state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A response on the final allowed cycle still beats the timeout
                if (C1 == C1_RESPONSE) begin
                    state_d = S_DONE;
                    case (cmd_q)
                        CMD_READ8: begin
                            rdata_d      = '0;
                            rdata_d[7:0] = D1[7:0];
                        end
                        CMD_READ16: begin
                            rdata_d             = '0;
                            rdata_d[DATA_W-1:0] = D1;
                        end
                        CMD_READ32: begin
                            rdata_d             = '0;
                            rdata_d[DATA_W-1:0] = D1;
                            state_d             = S_RECV;
                        end
                        default: ;
                    endcase
                end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECV: begin
                rdata_d[2*DATA_W-1:DATA_W] = D1;
                state_d                    = S_DONE;
            end
            S_DONE: begin
                resp_valid_d = port_onehot;
                resp_err_d   = err_q;
                resp_rdata_d = rdata_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus1_arbiter.sv
// Directed, table-driven bench for cpu_bus1_arbiter. The bench plays the
// cache side of A1/D1/C1 and checks the grant, the bus phases and the completion.
module tb_cpu_bus1_arbiter;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] RD8  = 3'd1;
    localparam logic [2:0] RD16 = 3'd2;
    localparam logic [2:0] RD32 = 3'd3;
    localparam logic [2:0] INV  = 3'd4;
    localparam logic [2:0] WR8  = 3'd5;
    localparam logic [2:0] WR16 = 3'd6;
    localparam logic [2:0] WR32 = 3'd7;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  req_valid;
    logic [2:0]  req_cmd0, req_cmd1;
    logic [18:0] req_addr0, req_addr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic [1:0]  req_ready, resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    wire  [14:0] A1;
    wire  [15:0] D1;
    wire  [2:0]  C1;

    // Cache-side drivers. When the bench drives zeros, any arbiter drive shows as non-zero.
    logic        tb_ac_en;
    logic        tb_d1_en;
    logic [15:0] tb_d1;
    logic [2:0]  tb_c1;

    assign A1 = tb_ac_en ? 15'd0 : 'z;
    assign D1 = tb_d1_en ? tb_d1 : 'z;
    assign C1 = tb_ac_en ? tb_c1 : 'z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    cpu_bus1_arbiter #(
        .ADDR_W(19), .OFFSET_W(4), .ADDR1_W(15), .DATA_W(16), .CTR1_W(3),
        .RESP_TIMEOUT(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid),
        .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .A1(A1), .D1(D1), .C1(C1)
    );

    typedef struct {
        int          port;
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        int          k;          // response sampled k cycles after bus release
        bit          has_resp;   // 0: cache stays silent (timeout)
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive zeros on all three bus lines and confirm nothing else drives them
    task automatic probe_released(input string tag);
        tb_ac_en = 1'b1;
        tb_d1_en = 1'b1;
        tb_d1    = 16'h0;
        tb_c1    = 3'd0;
        #1;
        check({tag, "_a1"}, 32'(A1), 32'h0);
        check({tag, "_d1"}, 32'(D1), 32'h0);
        check({tag, "_c1"}, 32'(C1), 32'h0);
    endtask

    // D1 must carry write data for writes and be left alone otherwise
    task automatic check_d1(input vec_t v, input logic [15:0] exp, input string name);
        if (v.cmd >= WR8) begin
            check(name, 32'(D1), 32'(exp));
        end else begin
            tb_d1_en = 1'b1;
            tb_d1    = 16'h0;
            #1;
            check(name, 32'(D1), 32'h0);
            tb_d1_en = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic [1:0] pmask;
        pmask = (v.port == 1) ? 2'b10 : 2'b01;
        if (v.port == 0) begin
            req_cmd0 = v.cmd; req_addr0 = v.addr; req_wdata0 = v.wdata;
        end else begin
            req_cmd1 = v.cmd; req_addr1 = v.addr; req_wdata1 = v.wdata;
        end
        req_valid = pmask;
        @(negedge CLK);                         // grant edge T has passed
        check("ready", 32'(req_ready), 32'(pmask));
        req_valid = 2'b00;
        if (v.cmd == NOP) begin
            probe_released("nop_bus");
            check("nop_pre_valid", 32'(resp_valid), 32'h0);
        end else begin
            check("s1_a1", 32'(A1), 32'(v.addr[18:4]));
            check("s1_c1", 32'(C1), 32'(v.cmd));
            check_d1(v, v.wdata[15:0], "s1_d1");
            @(negedge CLK);                     // SEND2
            check("s2_ready", 32'(req_ready), 32'h0);
            check("s2_a1", 32'(A1), 32'(v.addr[3:0]));
            check("s2_c1", 32'(C1), 32'(v.cmd));
            check_d1(v, v.wdata[31:16], "s2_d1");
            @(negedge CLK);                     // first WAIT_RESP cycle
            probe_released("rel");
            repeat (v.k - 1) @(negedge CLK);
            if (v.has_resp) begin
                tb_c1 = 3'd7;
                tb_d1 = v.rd0;
            end
            @(negedge CLK);                     // response sampled (or timeout)
            tb_c1 = 3'd0;
            tb_d1 = v.rd1;
            if (v.cmd == RD32) @(negedge CLK);  // second data beat
            check("pre_valid", 32'(resp_valid), 32'h0);
        end
        tb_ac_en = 1'b0;
        tb_d1_en = 1'b0;
        @(negedge CLK);
        check("valid", 32'(resp_valid), 32'(pmask));
        check("err", 32'(resp_err), 32'(v.exp_err));
        check("rdata", resp_rdata, v.exp_rdata);
        $display("[TB] txn %0d port=%0d cmd=%0d addr=0x%05h rdata=0x%08h err=%0b",
                 idx, v.port, v.cmd, v.addr, resp_rdata, resp_err);
        @(negedge CLK);
        check("valid_clr", 32'(resp_valid), 32'h0);
        check("rdata_clr", resp_rdata, 32'h0);
        check("err_clr", 32'(resp_err), 32'h0);
    endtask

    // Both ports request NOPs together; the first grant must go to 'first'
    task automatic nop_pair(input int first, input string tag);
        logic [1:0] m1, m2;
        m1 = (first == 1) ? 2'b10 : 2'b01;
        m2 = ~m1;
        req_cmd0  = NOP;
        req_cmd1  = NOP;
        req_valid = 2'b11;
        @(negedge CLK);
        check({tag, "_first"}, 32'(req_ready), 32'(m1));
        req_valid = m2;
        @(negedge CLK);
        check({tag, "_busy"}, 32'(req_ready), 32'h0);
        check({tag, "_v1"}, 32'(resp_valid), 32'(m1));
        @(negedge CLK);
        check({tag, "_second"}, 32'(req_ready), 32'(m2));
        req_valid = 2'b00;
        @(negedge CLK);
        check({tag, "_v2"}, 32'(resp_valid), 32'(m2));
        $display("[TB] arb %s first=%0d", tag, first);
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, WR32, 19'h00043, 32'h0025_C87C, 1, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1, RD32, 19'h00043, 32'h0000_0000, 2, 1'b1, 16'h1234, 16'hABCD, 32'hABCD_1234, 1'b0};
        vecs[2]  = '{0, RD8,  19'h1F0A5, 32'h0000_0000, 1, 1'b1, 16'hFF5A, 16'h0000, 32'h0000_005A, 1'b0};
        vecs[3]  = '{1, RD16, 19'h7FFFF, 32'h0000_0000, 3, 1'b1, 16'hBEEF, 16'h0000, 32'h0000_BEEF, 1'b0};
        vecs[4]  = '{0, NOP,  19'h12345, 32'hFFFF_FFFF, 1, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1, RD16, 19'h00120, 32'h0000_0000, 8, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{0, WR8,  19'h2ABCD, 32'h1234_5678, 4, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1, INV,  19'h00F00, 32'hDEAD_BEEF, 1, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{0, RD16, 19'h0ABC7, 32'h0000_0000, 8, 1'b1, 16'h4321, 16'h0000, 32'h0000_4321, 1'b0};
        vecs[9]  = '{1, RD32, 19'h3FFF0, 32'h0000_0000, 1, 1'b1, 16'h0001, 16'h8000, 32'h8000_0001, 1'b0};
        vecs[10] = '{0, WR16, 19'h55555, 32'hFFFF_0000, 2, 1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};

        RESET      = 1'b1;
        req_valid  = 2'b00;
        req_cmd0   = NOP;  req_cmd1   = NOP;
        req_addr0  = '0;   req_addr1  = '0;
        req_wdata0 = '0;   req_wdata1 = '0;
        tb_ac_en   = 1'b0; tb_d1_en   = 1'b0;
        tb_d1      = 16'h0; tb_c1     = 3'd0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_err", 32'(resp_err), 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        probe_released("rst_bus");
        tb_ac_en = 1'b0; tb_d1_en = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);

        // Round-robin: port0 first after reset, then port1; a lone port0 grant
        // leaves rr_ptr at 1 so the next tie goes to port1
        nop_pair(0, "arb_a");
        req_cmd0  = NOP;
        req_valid = 2'b01;
        @(negedge CLK);
        check("arb_solo_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        repeat (2) @(negedge CLK);
        nop_pair(1, "arb_b");

        // Table of single-port transactions
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset in the middle of SEND2: bus released without a clock edge, no response
        req_cmd0   = WR32;
        req_addr0  = 19'h00043;
        req_wdata0 = 32'h0025_C87C;
        req_valid  = 2'b01;
        @(negedge CLK);
        check("mid_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        @(negedge CLK);
        check("mid_s2_a1", 32'(A1), 32'h3);
        #1 RESET = 1'b1;
        #1;
        probe_released("mid_rst");
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        tb_ac_en = 1'b0; tb_d1_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("mid_no_resp", 32'(resp_valid), 32'h0);
        end
        $display("[TB] reset during SEND2 done");

        // rr_ptr back to 0: a tie goes to port0, then a fresh port0 write completes
        req_cmd0  = NOP;
        req_cmd1  = NOP;
        req_valid = 2'b11;
        @(negedge CLK);
        check("post_rst_rr", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        repeat (3) @(negedge CLK);
        run_txn(vecs[0], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
